// File: rtl/status_reg.sv
// Processor status (P) register: ALU flag capture, set/clear ops, PLP/RTI loads,
// stack-push formatting and the instruction-boundary delayed IRQ mask.
module status_reg #(
    parameter logic [7:0] RESET_P = 8'h24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] alu_out,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       bit_op,
    input  logic [7:0] data_in,
    input  logic       load_p,
    input  logic       load_p_rti,
    input  logic [2:0] flag_op,
    input  logic       set_i_int,
    input  logic       sync,
    input  logic       push_brk,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_i,
    output logic       flag_d,
    output logic       flag_v,
    output logic       flag_n,
    output logic       irq_mask
);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_CLC  = 3'd1,
        OP_SEC  = 3'd2,
        OP_CLI  = 3'd3,
        OP_SEI  = 3'd4,
        OP_CLD  = 3'd5,
        OP_SED  = 3'd6,
        OP_CLV  = 3'd7
    } flag_op_e;

    flag_op_e op;

    logic n_q, v_q, d_q, i_q, z_q, c_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d;
    logic irq_mask_q, irq_mask_d;
    logic alu_zero;

    assign op       = flag_op_e'(flag_op);
    assign alu_zero = (alu_out == 8'h00);

    // Lowest-priority sources are applied first so later assignments win.
    always_comb begin
        n_d = n_q;
        v_d = v_q;
        d_d = d_q;
        i_d = i_q;
        z_d = z_q;
        c_d = c_q;

        if (load_p || load_p_rti) begin
            n_d = data_in[7];
            v_d = data_in[6];
            d_d = data_in[3];
            i_d = data_in[2];
            z_d = data_in[1];
            c_d = data_in[0];
        end else begin
            if (upd_nz) begin
                n_d = alu_out[7];
                z_d = alu_zero;
            end
            if (upd_c) c_d = alu_c;
            if (upd_v) v_d = alu_v;
            if (bit_op) begin
                n_d = data_in[7];
                v_d = data_in[6];
                z_d = alu_zero;
            end

            case (op)
                OP_CLC:  c_d = 1'b0;
                OP_SEC:  c_d = 1'b1;
                OP_CLI:  i_d = 1'b0;
                OP_SEI:  i_d = 1'b1;
                OP_CLD:  d_d = 1'b0;
                OP_SED:  d_d = 1'b1;
                OP_CLV:  v_d = 1'b0;
                default: ;
            endcase

            if (set_i_int) i_d = 1'b1;
        end
    end

    // The mask samples I as stored before this edge, giving the one-instruction delay.
    always_comb begin
        irq_mask_d = irq_mask_q;
        if (load_p_rti) begin
            irq_mask_d = data_in[2];
        end else if (sync) begin
            irq_mask_d = i_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q        <= RESET_P[7];
            v_q        <= RESET_P[6];
            d_q        <= RESET_P[3];
            i_q        <= RESET_P[2];
            z_q        <= RESET_P[1];
            c_q        <= RESET_P[0];
            irq_mask_q <= 1'b1;
        end else begin
            n_q        <= n_d;
            v_q        <= v_d;
            d_q        <= d_d;
            i_q        <= i_d;
            z_q        <= z_d;
            c_q        <= c_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    assign p_out    = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
    assign p_push   = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
    assign flag_n   = n_q;
    assign flag_v   = v_q;
    assign flag_d   = d_q;
    assign flag_i   = i_q;
    assign flag_z   = z_q;
    assign flag_c   = c_q;
    assign irq_mask = irq_mask_q;

endmodule

// File: tb/tb_status_reg.sv
// Scoreboard bench for status_reg: directed plan steps plus random traffic
// checked against a byte-level model of the P register.
module tb_status_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] alu_out;
    logic       alu_c, alu_v;
    logic       upd_nz, upd_c, upd_v, bit_op;
    logic [7:0] data_in;
    logic       load_p, load_p_rti;
    logic [2:0] flag_op;
    logic       set_i_int, sync, push_brk;
    logic [7:0] p_out, p_push;
    logic       flag_c, flag_z, flag_i, flag_d, flag_v, flag_n, irq_mask;

    always #5 clk = ~clk;

    status_reg #(.RESET_P(8'h24)) dut (
        .clk(clk), .rst_n(rst_n), .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v),
        .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_op(bit_op),
        .data_in(data_in), .load_p(load_p), .load_p_rti(load_p_rti),
        .flag_op(flag_op), .set_i_int(set_i_int), .sync(sync), .push_brk(push_brk),
        .p_out(p_out), .p_push(p_push), .flag_c(flag_c), .flag_z(flag_z),
        .flag_i(flag_i), .flag_d(flag_d), .flag_v(flag_v), .flag_n(flag_n),
        .irq_mask(irq_mask)
    );

    typedef struct {
        logic [7:0] p;
        logic       irq;
        logic       brk;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: P as a byte with bits 5,4 always 1, plus the mask.
    logic [7:0] mp;
    logic       mirq;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", nm, act, req);
        end
    endtask

    task automatic idle();
        rst_n = 1'b1; alu_out = '0; alu_c = 1'b0; alu_v = 1'b0;
        upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0; bit_op = 1'b0;
        data_in = '0; load_p = 1'b0; load_p_rti = 1'b0; flag_op = 3'd0;
        set_i_int = 1'b0; sync = 1'b0; push_brk = 1'b0;
    endtask

    // Apply the rules to the current inputs, queue the expectation, advance one cycle.
    task automatic tick(input string nm);
        exp_t e;
        logic [7:0] np;
        logic       nirq;
        if (!rst_n) begin
            np = 8'h34;
            nirq = 1'b1;
        end else begin
            nirq = load_p_rti ? data_in[2] : (sync ? mp[2] : mirq);
            if (load_p || load_p_rti) begin
                np = data_in | 8'h30;
            end else begin
                np = mp;
                if (upd_nz) begin
                    np[7] = alu_out[7];
                    np[1] = (alu_out == 0);
                end
                if (upd_c) np[0] = alu_c;
                if (upd_v) np[6] = alu_v;
                if (bit_op) begin
                    np[7] = data_in[7];
                    np[6] = data_in[6];
                    np[1] = (alu_out == 0);
                end
                case (flag_op)
                    3'd1: np[0] = 1'b0;
                    3'd2: np[0] = 1'b1;
                    3'd3: np[2] = 1'b0;
                    3'd4: np[2] = 1'b1;
                    3'd5: np[3] = 1'b0;
                    3'd6: np[3] = 1'b1;
                    3'd7: np[6] = 1'b0;
                    default: ;
                endcase
                if (set_i_int) np[2] = 1'b1;
            end
        end
        mp = np;
        mirq = nirq;
        e.p = np; e.irq = nirq; e.brk = push_brk; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        logic [7:0] pp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                pp = e.p;
                pp[4] = e.brk;
                chk({e.name, ".p_out"}, p_out, e.p);
                chk({e.name, ".irq_mask"}, {7'd0, irq_mask}, {7'd0, e.irq});
                chk({e.name, ".p_push"}, p_push, pp);
                chk({e.name, ".flags"},
                    {2'b00, flag_n, flag_v, flag_d, flag_i, flag_z, flag_c},
                    {2'b00, e.p[7], e.p[6], e.p[3:0]});
            end
        end
    end

    initial begin : stimulus
        idle();
        rst_n = 1'b0;
        tick("reset0");
        rst_n = 1'b0;
        tick("reset1");
        rst_n = 1'b0; push_brk = 1'b1;
        tick("reset_brk");

        // ALU updates
        alu_out = 8'h80; alu_c = 1'b1; alu_v = 1'b1; upd_nz = 1'b1; upd_c = 1'b1; upd_v = 1'b1;
        tick("alu_all");
        idle(); alu_out = 8'h00; upd_nz = 1'b1; alu_c = 1'b0; alu_v = 1'b0;
        tick("alu_nz_only");

        // CLI/SEI delay through sync
        idle(); flag_op = 3'd3; sync = 1'b1;
        tick("cli_sync");
        idle(); sync = 1'b1;
        tick("sync_after_cli");
        idle(); flag_op = 3'd4;
        tick("sei");
        idle(); sync = 1'b1;
        tick("sync_after_sei");

        // PLP vs RTI
        idle(); load_p = 1'b1; data_in = 8'hFF; upd_nz = 1'b1; flag_op = 3'd1;
        tick("plp_ff");
        idle(); sync = 1'b1;
        tick("sync_after_plp");
        idle(); load_p_rti = 1'b1; data_in = 8'h00;
        tick("rti_00");

        // BIT and interrupt entry
        idle(); bit_op = 1'b1; data_in = 8'hC0; alu_out = 8'h00;
        tick("bit");
        idle(); set_i_int = 1'b1; flag_op = 3'd3;
        tick("int_entry_cli");
        idle(); alu_v = 1'b1; upd_v = 1'b1; flag_op = 3'd7; upd_c = 1'b1; alu_c = 1'b1;
        tick("clv_over_alu");

        // Mid-operation reset with all flags set and mask clear
        idle(); load_p_rti = 1'b1; data_in = 8'hFB;
        tick("rti_fb");
        idle(); flag_op = 3'd4;
        tick("sei_all_set");
        idle(); rst_n = 1'b0; load_p = 1'b1; data_in = 8'hFF;
        tick("reset_mid");

        for (int unsigned k = 0; k < 400; k++) begin
            idle();
            rst_n      = ($urandom_range(0, 39) != 0);
            alu_out    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            alu_c      = 1'($urandom);
            alu_v      = 1'($urandom);
            upd_nz     = 1'($urandom);
            upd_c      = 1'($urandom);
            upd_v      = 1'($urandom);
            bit_op     = ($urandom_range(0, 3) == 0);
            data_in    = 8'($urandom);
            load_p     = ($urandom_range(0, 9) == 0);
            load_p_rti = ($urandom_range(0, 9) == 0);
            flag_op    = 3'($urandom);
            set_i_int  = ($urandom_range(0, 5) == 0);
            sync       = 1'($urandom);
            push_brk   = 1'($urandom);
            tick("rand");
        end

        idle();
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/status_reg.md
Name: status_reg

Overview:
- Processor status (P) register that consumes the ALU result interface: 8-bit result, carry-out and overflow-out.
- Applies per-instruction flag-update masks and explicit set/clear ops.
- Loads P from the data bus for PLP/RTI.
- Formats P for stack pushes (BRK/PHP vs IRQ/NMI).
- Maintains the delayed IRQ mask sampled at instruction boundaries, which the interrupt controller uses.

Parameters:
- RESET_P, 8'h24, P value after reset: I=1, bit5=1, all other flags 0.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- alu_out  in  8  ALU result
- alu_c  in  1  ALU carry-out
- alu_v  in  1  ALU overflow-out
- upd_nz  in  1  update N,Z from alu_out
- upd_c  in  1  update C from alu_c
- upd_v  in  1  update V from alu_v
- bit_op  in  1  BIT: N<=data_in[7], V<=data_in[6], Z<=(alu_out==0)
- data_in  in  8  data bus, used for PLP/RTI/BIT
- load_p  in  1  PLP: P<=data_in (bits 5,4 ignored)
- load_p_rti  in  1  RTI: as load_p, and irq_mask updates immediately
- flag_op  in  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLD, 6 SED, 7 CLV
- set_i_int  in  1  interrupt entry: I<=1
- sync  in  1  instruction-boundary strobe from sequencer
- push_brk  in  1  B bit value for p_push
- p_out  out  8  {N,V,1,1,D,I,Z,C}, architectural view
- p_push  out  8  {N,V,1,push_brk,D,I,Z,C}, combinational
- flag_c, flag_z, flag_i, flag_d, flag_v, flag_n  out  1 each  current flags, used for branches/ALU carry-in/decimal
- irq_mask  out  1  effective IRQ mask

Behaviour:
- Stored state: six flag flops (N,V,D,I,Z,C) and irq_mask. B and bit5 are not stored.
  - p_out[5:4] are constant 2'b11.
  - p_push[4]=push_brk.
- Reset (rst_n=0 at edge): flags <= RESET_P bits, so I=1 and all others 0; irq_mask <= 1. Reset overrides all inputs, including a reset asserted mid-instruction.
- Latency: every update is visible on flag outputs/p_out the cycle after the enabling edge. p_push is combinational from the registers plus push_brk.
- Per-edge priority, highest first:
  1. load_p_rti or load_p: all six flags <= data_in[7,6,3,2,1,0]. Every other update source is ignored this cycle.
  2. set_i_int: I<=1. Other sources for I are ignored; non-I updates from flag_op (except CLI/SEI) and the ALU still apply.
  3. flag_op: modifies its single flag.
  4. ALU updates.
- A flag targeted by both flag_op and an ALU update takes the flag_op value. Sequencer should not issue this; bench checks priority anyway.
- ALU updates:
  - upd_nz: N<=alu_out[7], Z<=(alu_out==8'h00).
  - upd_c: C<=alu_c.
  - upd_v: V<=alu_v.
  - bit_op: N<=data_in[7], V<=data_in[6], Z<=(alu_out==0). bit_op overrides upd_nz/upd_v for N and V if both are asserted.
  - All enables are independent; any subset may be asserted together.
- irq_mask:
  - With sync=1 and no load_p_rti: irq_mask <= I as stored before this edge. The pre-update value models the one-instruction delay of CLI/SEI/PLP.
  - load_p_rti: irq_mask <= data_in[2] at the same edge, whatever sync is.
  - Otherwise irq_mask holds.
- No X propagation: unused enables leave flags unchanged. flag_op encodings 0 and 7 are both defined.

Test Plan:
1. Reset with rst_n=0 held 2 cycles, then released -> p_out=8'h34 (RESET_P plus constant bits 5,4), irq_mask=1, p_push=8'h24 with push_brk=0 and 8'h34 with push_brk=1.
2. ALU update with alu_out=8'h80, alu_c=1, alu_v=1, upd_nz=upd_c=upd_v=1 -> next cycle N=1,Z=0,C=1,V=1. Then alu_out=8'h00 with upd_nz only -> Z=1,N=0, C and V unchanged.
3. CLI delay: flag_op=CLI with sync=1 on the same edge -> flag_i=0 but irq_mask stays 1. Next sync -> irq_mask=0. Then SEI -> I=1 immediately, irq_mask=1 only after the following sync.
4. PLP vs RTI:
   - load_p, data_in=8'hFF, with upd_nz=1 and flag_op=CLC -> p_out=8'hFF (data wins); irq_mask changes only at next sync.
   - load_p_rti, data_in=8'h00 -> p_out=8'h30 and irq_mask=0 at the same edge.
5. BIT: bit_op=1, data_in=8'hC0, alu_out=8'h00 -> N=1, V=1, Z=1, C unchanged. Interrupt entry: set_i_int=1 with flag_op=CLI -> I=1.
6. Mid-operation reset: with flags all set and irq_mask=0, assert rst_n=0 together with load_p=1 -> p_out=8'h34, irq_mask=1.
